// File: rtl/coeff_token_pkg.sv
// coeff_token_pkg
//   Shared types and constants for the H.264 CAVLC coeff_token decoder.
//   The VLC tables are stored as (length, code) pairs indexed by
//   TotalCoeff*4 + TrailingOnes. A length of 0 marks a combination that has
//   no codeword in that table.
package coeff_token_pkg;

    typedef enum logic [2:0] {
        CLS_T0,     // 0 <= nC < 2
        CLS_T1,     // 2 <= nC < 4
        CLS_T2,     // 4 <= nC < 8
        CLS_FLC,    // 8 <= nC, 6-bit fixed-length code
        CLS_TCD     // nC == -1, chroma DC
    } table_class_e;

    localparam int TC_W    = 5;
    localparam int T1_W    = 2;
    localparam int LEN_W   = 5;
    localparam int ZC_W    = 5;
    localparam int WIN_W   = 16;
    localparam int LZC_SAT = 16;
    localparam int N_ENTRY = 68;   // 17 TotalCoeff values x 4 TrailingOnes values
    localparam int N_TCD   = 20;   // chroma DC only goes up to TotalCoeff = 4

    localparam int LEN_T0 [N_ENTRY] = '{
        1, 0, 0, 0,     6, 2, 0, 0,     8, 6, 3, 0,     9, 8, 7, 5,
        10, 9, 8, 6,    11, 10, 9, 7,   13, 11, 10, 8,  13, 13, 11, 9,
        13, 13, 13, 10, 14, 14, 13, 11, 14, 14, 14, 13, 15, 15, 14, 14,
        15, 15, 15, 14, 16, 15, 15, 15, 16, 16, 16, 15, 16, 16, 16, 16,
        16, 16, 16, 16};
    localparam int CODE_T0 [N_ENTRY] = '{
        1, 0, 0, 0,     5, 1, 0, 0,     7, 4, 1, 0,     7, 6, 5, 3,
        7, 6, 5, 3,     7, 6, 5, 4,     15, 6, 5, 4,    11, 14, 5, 4,
        8, 10, 13, 4,   15, 14, 9, 4,   11, 10, 13, 12, 15, 14, 9, 12,
        11, 10, 13, 8,  15, 1, 9, 12,   11, 14, 13, 8,  7, 10, 9, 12,
        4, 6, 5, 8};
    localparam int LEN_T1 [N_ENTRY] = '{
        2, 0, 0, 0,     6, 2, 0, 0,     6, 5, 3, 0,     7, 6, 6, 4,
        8, 6, 6, 4,     8, 7, 7, 5,     9, 8, 8, 6,     11, 9, 9, 6,
        11, 11, 11, 7,  12, 11, 11, 9,  12, 12, 12, 11, 12, 12, 12, 11,
        13, 13, 13, 12, 13, 13, 13, 13, 13, 14, 13, 13, 14, 14, 14, 13,
        14, 14, 14, 14};
    localparam int CODE_T1 [N_ENTRY] = '{
        3, 0, 0, 0,     11, 2, 0, 0,    7, 7, 3, 0,     7, 10, 9, 5,
        7, 6, 5, 4,     4, 6, 5, 6,     7, 6, 5, 8,     15, 6, 5, 4,
        11, 14, 13, 4,  15, 10, 9, 4,   11, 14, 13, 12, 8, 10, 9, 8,
        15, 14, 13, 12, 11, 10, 9, 12,  7, 11, 6, 8,    9, 8, 10, 1,
        7, 6, 5, 4};
    localparam int LEN_T2 [N_ENTRY] = '{
        4, 0, 0, 0,     6, 4, 0, 0,     6, 5, 4, 0,     6, 5, 5, 4,
        7, 5, 5, 4,     7, 5, 5, 4,     7, 6, 6, 4,     7, 6, 6, 4,
        8, 7, 7, 5,     8, 8, 7, 6,     9, 8, 8, 7,     9, 9, 8, 8,
        9, 9, 9, 8,     10, 9, 9, 9,    10, 10, 10, 10, 10, 10, 10, 10,
        10, 10, 10, 10};
    localparam int CODE_T2 [N_ENTRY] = '{
        15, 0, 0, 0,    15, 14, 0, 0,   11, 15, 13, 0,  8, 12, 14, 12,
        15, 10, 11, 11, 11, 8, 9, 10,   9, 14, 13, 9,   8, 10, 9, 8,
        15, 14, 13, 13, 11, 14, 10, 12, 15, 10, 13, 12, 11, 14, 9, 12,
        8, 10, 13, 8,   13, 7, 9, 12,   9, 12, 11, 10,  5, 8, 7, 6,
        1, 4, 3, 2};
    localparam int LEN_TCD [N_TCD] = '{
        2, 0, 0, 0,     6, 1, 0, 0,     6, 6, 3, 0,     6, 7, 7, 6,
        6, 8, 8, 7};
    localparam int CODE_TCD [N_TCD] = '{
        1, 0, 0, 0,     7, 1, 0, 0,     4, 6, 1, 0,     3, 3, 2, 5,
        2, 3, 2, 0};

    // Leading-zero count of a 16-bit window; an all-zero window reports 16.
    function automatic logic [ZC_W-1:0] lzc16(input logic [WIN_W-1:0] win);
        logic [ZC_W-1:0] n;
        n = ZC_W'(LZC_SAT);
        for (int i = 0; i < WIN_W; i++) begin
            if (win[i]) n = ZC_W'(WIN_W - 1 - i);
        end
        return n;
    endfunction

endpackage

// File: rtl/coeff_token_table.sv
// coeff_token_table
//   Combinational coeff_token lookup for one table class.
//   Ports:
//     i_class          table selected from nC
//     i_zeros          leading-zero count of i_window (0..16)
//     i_window         16-bit left-aligned bitstream window
//     o_total_coeff    decoded TotalCoeff (0 on error)
//     o_trailing_ones  decoded TrailingOnes (0 on error)
//     o_length         codeword length (0 on error)
//     o_error          no legal codeword matched
module coeff_token_table
    import coeff_token_pkg::*;
(
    input  table_class_e      i_class,
    input  logic [ZC_W-1:0]   i_zeros,
    input  logic [WIN_W-1:0]  i_window,
    output logic [TC_W-1:0]   o_total_coeff,
    output logic [T1_W-1:0]   o_trailing_ones,
    output logic [LEN_W-1:0]  o_length,
    output logic              o_error
);

    function automatic int entry_len(input table_class_e c, input int e);
        case (c)
            CLS_T0:  return LEN_T0[e];
            CLS_T1:  return LEN_T1[e];
            CLS_T2:  return LEN_T2[e];
            CLS_TCD: return (e < N_TCD) ? LEN_TCD[e] : 0;
            default: return 0;
        endcase
    endfunction

    function automatic int entry_code(input table_class_e c, input int e);
        case (c)
            CLS_T0:  return CODE_T0[e];
            CLS_T1:  return CODE_T1[e];
            CLS_T2:  return CODE_T2[e];
            CLS_TCD: return (e < N_TCD) ? CODE_TCD[e] : 0;
            default: return 0;
        endcase
    endfunction

    // A codeword is keyed by its leading-zero run and then the bits that
    // follow it. The only codeword with no '1' (chroma DC 0000000) matches
    // any window with at least that many leading zeros.
    function automatic logic code_hit(input int len, input int code,
                                      input logic [ZC_W-1:0] zeros,
                                      input logic [WIN_W-1:0] win);
        int          hb;
        logic [31:0] prefix;
        if (len == 0) return 1'b0;
        hb = 0;
        for (int i = 0; i < WIN_W; i++) begin
            if (code[i]) hb = i + 1;
        end
        prefix = 32'(win) >> (WIN_W - len);
        if (hb == 0) return (int'(zeros) >= len) && (prefix == $unsigned(code));
        return (int'(zeros) == len - hb) && (prefix == $unsigned(code));
    endfunction

    logic              w_hit;
    logic [TC_W-1:0]   w_tc;
    logic [T1_W-1:0]   w_t1;
    logic [LEN_W-1:0]  w_len;
    logic [5:0]        w_flc;

    always_comb begin
        w_hit = 1'b0;
        w_tc  = '0;
        w_t1  = '0;
        w_len = '0;
        w_flc = i_window[WIN_W-1 -: 6];
        if (i_class == CLS_FLC) begin
            w_len = 5'd6;
            if (w_flc == 6'b000011) begin
                // 000011 is the escape for TotalCoeff = 0
                w_hit = 1'b1;
            end else begin
                w_tc  = {1'b0, w_flc[5:2]} + 5'd1;
                w_t1  = w_flc[1:0];
                w_hit = ({3'b000, w_flc[1:0]} <= w_tc);
            end
        end else begin
            for (int e = 0; e < N_ENTRY; e++) begin
                if (!w_hit && code_hit(entry_len(i_class, e), entry_code(i_class, e),
                                       i_zeros, i_window)) begin
                    w_hit = 1'b1;
                    w_tc  = TC_W'(e / 4);
                    w_t1  = T1_W'(e % 4);
                    w_len = LEN_W'(entry_len(i_class, e));
                end
            end
        end
    end

    assign o_error         = !w_hit;
    assign o_total_coeff   = w_hit ? w_tc  : '0;
    assign o_trailing_ones = w_hit ? w_t1  : '0;
    assign o_length        = w_hit ? w_len : '0;

endmodule

// File: rtl/coeff_token_decoder.sv
// coeff_token_decoder
//   Two-stage pipelined H.264 CAVLC coeff_token decoder with valid/ready
//   handshakes on both sides. Stage 1 registers the table class, the
//   leading-zero count and the top 16 bits of the window; stage 2 registers
//   the table lookup result, which drives the outputs directly.
//   Ports:
//     Clk, Rst                      clock, synchronous active-high reset
//     InValid/InReady, Bits, nC     request handshake, window (MSB first), nC
//     OutValid/OutReady             result handshake
//     TotalCoeff, TrailingOnes,
//     Length, Error                 decoded result
module coeff_token_decoder
    import coeff_token_pkg::*;
#(
    parameter int WINDOW_W     = 16,
    parameter int CHROMA_DC_EN = 1
)
(
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 InValid,
    output logic                 InReady,
    input  logic [WINDOW_W-1:0]  Bits,
    input  logic signed [5:0]    nC,
    output logic                 OutValid,
    input  logic                 OutReady,
    output logic [TC_W-1:0]      TotalCoeff,
    output logic [T1_W-1:0]      TrailingOnes,
    output logic [LEN_W-1:0]     Length,
    output logic                 Error
);

    logic              r_s1_valid;
    table_class_e      r_s1_class;
    logic              r_s1_bad;
    logic [ZC_W-1:0]   r_s1_zeros;
    logic [WIN_W-1:0]  r_s1_window;

    logic              r_s2_valid;
    logic [TC_W-1:0]   r_s2_tc;
    logic [T1_W-1:0]   r_s2_t1;
    logic [LEN_W-1:0]  r_s2_len;
    logic              r_s2_err;

    logic [WIN_W-1:0]  w_window;
    table_class_e      w_class;
    logic              w_bad;
    logic              w_adv2;
    logic [TC_W-1:0]   w_tbl_tc;
    logic [T1_W-1:0]   w_tbl_t1;
    logic [LEN_W-1:0]  w_tbl_len;
    logic              w_tbl_err;

    assign w_window = Bits[WINDOW_W-1 -: WIN_W];
    assign w_adv2   = !r_s2_valid || OutReady;
    // Stage 1 can take a new request if it is empty or is moving on.
    assign InReady  = !r_s1_valid || w_adv2;

    // nC values with no table (and nC = -1 when chroma DC is disabled) are
    // flagged here and forced to an error result in stage 2.
    always_comb begin
        w_class = CLS_T0;
        w_bad   = 1'b0;
        if (nC == -6'sd1) begin
            w_class = CLS_TCD;
            w_bad   = (CHROMA_DC_EN == 0);
        end else if (nC < 6'sd0 || nC > 6'sd16) begin
            w_bad   = 1'b1;
        end else if (nC <= 6'sd1) begin
            w_class = CLS_T0;
        end else if (nC <= 6'sd3) begin
            w_class = CLS_T1;
        end else if (nC <= 6'sd7) begin
            w_class = CLS_T2;
        end else begin
            w_class = CLS_FLC;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_s1_valid  <= 1'b0;
            r_s1_class  <= CLS_T0;
            r_s1_bad    <= 1'b0;
            r_s1_zeros  <= '0;
            r_s1_window <= '0;
        end else if (InReady) begin
            r_s1_valid <= InValid;
            if (InValid) begin
                r_s1_class  <= w_class;
                r_s1_bad    <= w_bad;
                r_s1_zeros  <= lzc16(w_window);
                r_s1_window <= w_window;
            end
        end
    end

    coeff_token_table u_table (
        .i_class         (r_s1_class),
        .i_zeros         (r_s1_zeros),
        .i_window        (r_s1_window),
        .o_total_coeff   (w_tbl_tc),
        .o_trailing_ones (w_tbl_t1),
        .o_length        (w_tbl_len),
        .o_error         (w_tbl_err)
    );

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_s2_valid <= 1'b0;
            r_s2_tc    <= '0;
            r_s2_t1    <= '0;
            r_s2_len   <= '0;
            r_s2_err   <= 1'b0;
        end else if (w_adv2) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_tc  <= r_s1_bad ? '0 : w_tbl_tc;
                r_s2_t1  <= r_s1_bad ? '0 : w_tbl_t1;
                r_s2_len <= r_s1_bad ? '0 : w_tbl_len;
                r_s2_err <= r_s1_bad | w_tbl_err;
            end
        end
    end

    assign OutValid     = r_s2_valid;
    assign TotalCoeff   = r_s2_tc;
    assign TrailingOnes = r_s2_t1;
    assign Length       = r_s2_len;
    assign Error        = r_s2_err;

endmodule

// File: tb/tb_coeff_token_decoder.sv
// tb_coeff_token_decoder
//   Directed bench: single requests with hand-computed results, a
//   back-pressure run with a scoreboard and occupancy model, and reset
//   with both stages full. A second instance has chroma DC disabled.
module tb_coeff_token_decoder;

    logic              Clk = 1'b0;
    logic              Rst = 1'b1;
    logic              InValid = 1'b0;
    logic              OutReady = 1'b0;
    logic [15:0]       Bits = '0;
    logic signed [5:0] nC = '0;

    logic       InReady, OutValid, Error;
    logic [4:0] TotalCoeff, Length;
    logic [1:0] TrailingOnes;
    logic       InReady_b, OutValid_b, Error_b;
    logic [4:0] TotalCoeff_b, Length_b;
    logic [1:0] TrailingOnes_b;

    int n_checks = 0;
    int n_errors = 0;

    always #5 Clk = ~Clk;

    coeff_token_decoder dut (
        .Clk(Clk), .Rst(Rst), .InValid(InValid), .InReady(InReady),
        .Bits(Bits), .nC(nC), .OutValid(OutValid), .OutReady(OutReady),
        .TotalCoeff(TotalCoeff), .TrailingOnes(TrailingOnes),
        .Length(Length), .Error(Error)
    );

    coeff_token_decoder #(.WINDOW_W(16), .CHROMA_DC_EN(0)) dut_nodc (
        .Clk(Clk), .Rst(Rst), .InValid(InValid), .InReady(InReady_b),
        .Bits(Bits), .nC(nC), .OutValid(OutValid_b), .OutReady(OutReady),
        .TotalCoeff(TotalCoeff_b), .TrailingOnes(TrailingOnes_b),
        .Length(Length_b), .Error(Error_b)
    );

    typedef struct {
        string       tag;
        int          nc;
        logic [15:0] bits;
        int          tc;
        int          t1;
        int          len;
        int          err;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] pack(input int tc, input int t1, input int len, input int err);
        return {19'b0, 1'(err), 5'(tc), 2'(t1), 5'(len)};
    endfunction

    task automatic add(input string tag, input int nc, input logic [15:0] bits,
                       input int tc, input int t1, input int len, input int err);
        vec_t v;
        v.tag = tag; v.nc = nc; v.bits = bits;
        v.tc = tc; v.t1 = t1; v.len = len; v.err = err;
        vecs.push_back(v);
    endtask

    // Entered at posedge+1 with an empty pipeline; checks the 2-cycle latency.
    task automatic run_one(input vec_t v);
        logic [31:0] exp_b;
        InValid = 1'b1; nC = 6'(v.nc); Bits = v.bits; OutReady = 1'b1;
        @(negedge Clk);
        chk({v.tag, "_inready"}, 32'(InReady), 32'd1);
        @(posedge Clk); #1;
        InValid = 1'b0;
        chk({v.tag, "_lat1"}, 32'(OutValid), 32'd0);
        @(posedge Clk); #1;
        chk({v.tag, "_valid"}, 32'(OutValid), 32'd1);
        chk({v.tag, "_tc"},  32'(TotalCoeff),   32'(v.tc));
        chk({v.tag, "_t1"},  32'(TrailingOnes), 32'(v.t1));
        chk({v.tag, "_len"}, 32'(Length),       32'(v.len));
        chk({v.tag, "_err"}, 32'(Error),        32'(v.err));
        exp_b = (v.nc == -1) ? pack(0, 0, 0, 1) : pack(v.tc, v.t1, v.len, v.err);
        chk({v.tag, "_nodc"}, pack(TotalCoeff_b, TrailingOnes_b, Length_b, Error_b), exp_b);
        $display("txn %s nC=%0d bits=%h -> tc=%0d t1=%0d len=%0d err=%0d",
                 v.tag, v.nc, v.bits, TotalCoeff, TrailingOnes, Length, Error);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int sent, received, occ, cyc;
        logic acc, con;
        logic pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

        add("t0_1",      0, 16'h8000,  0, 0,  1, 0);
        add("t0_01",     1, 16'h5A5A,  1, 1,  2, 0);
        add("t1_10",     3, 16'hA5A5,  1, 1,  2, 0);
        add("t2_1111",   5, 16'hFFFF,  0, 0,  4, 0);
        add("flc_0",    10, 16'h0C00,  0, 0,  6, 0);
        add("flc_2_0",  10, 16'h1000,  2, 0,  6, 0);
        add("flc_bad",  10, 16'h0800,  0, 0,  0, 1);
        add("tcd_1",    -1, 16'hBFFF,  1, 1,  1, 0);
        add("tcd_01",   -1, 16'h4000,  0, 0,  2, 0);
        add("tcd_zero", -1, 16'h0000,  4, 3,  7, 0);
        add("t0_long",   0, 16'h0002, 13, 1, 15, 0);
        add("t0_none",   0, 16'h0000,  0, 0,  0, 1);
        add("t1_001011", 2, 16'h2C00,  1, 0,  6, 0);
        add("t2_tc16",   7, 16'h0040, 16, 0, 10, 0);
        add("flc_max",  16, 16'hFC00, 16, 3,  6, 0);
        add("flc_t1gt",  8, 16'h1C00,  0, 0,  0, 1);
        add("nc_hi",    20, 16'h8000,  0, 0,  0, 1);
        add("nc_neg2",  -2, 16'h8000,  0, 0,  0, 1);

        // Reset state
        repeat (3) @(posedge Clk);
        #1 Rst = 1'b0;
        chk("rst_outvalid", 32'(OutValid), 32'd0);
        chk("rst_inready",  32'(InReady),  32'd1);
        chk("rst_fields", pack(TotalCoeff, TrailingOnes, Length, Error), pack(0, 0, 0, 0));

        foreach (vecs[i]) run_one(vecs[i]);
        @(posedge Clk); #1;

        // Back-to-back requests under OutReady pattern 1,0,0,1
        sent = 0; received = 0; occ = 0; cyc = 0;
        while (received < 8 && cyc < 200) begin
            OutReady = pat[cyc % 4];
            InValid  = (sent < 8);
            if (sent < 8) begin
                nC = 6'(vecs[sent].nc);
                Bits = vecs[sent].bits;
            end
            @(negedge Clk);
            chk("bp_inready", 32'(InReady), 32'(!(occ == 2 && !OutReady)));
            acc = InValid && InReady;
            con = OutValid && OutReady;
            if (OutValid) begin
                chk($sformatf("bp_res%0d", received),
                    pack(TotalCoeff, TrailingOnes, Length, Error),
                    pack(vecs[received].tc, vecs[received].t1, vecs[received].len, vecs[received].err));
            end
            if (con) begin
                $display("bp result %0d tag=%s tc=%0d t1=%0d len=%0d err=%0d",
                         received, vecs[received].tag, TotalCoeff, TrailingOnes, Length, Error);
                received++;
            end
            if (acc) sent++;
            occ = occ + int'(acc) - int'(con);
            @(posedge Clk); #1;
            cyc++;
        end
        chk("bp_received", 32'(received), 32'd8);
        InValid = 1'b0; OutReady = 1'b1;
        repeat (3) begin
            @(negedge Clk);
            chk("bp_no_dup", 32'(OutValid), 32'd0);
        end
        @(posedge Clk); #1;

        // Reset with both stages full
        OutReady = 1'b0; InValid = 1'b1; nC = 6'sd5; Bits = 16'hFFFF;
        @(posedge Clk); #1;
        nC = 6'sd0; Bits = 16'h8000;
        @(posedge Clk); #1;
        chk("full_outvalid", 32'(OutValid), 32'd1);
        chk("full_inready",  32'(InReady),  32'd0);
        $display("txn full pipeline before reset tc=%0d len=%0d", TotalCoeff, Length);
        Rst = 1'b1; OutReady = 1'b1;
        @(posedge Clk); #1;
        Rst = 1'b0; InValid = 1'b0;
        chk("mid_rst_outvalid", 32'(OutValid), 32'd0);
        chk("mid_rst_inready",  32'(InReady),  32'd1);
        chk("mid_rst_fields", pack(TotalCoeff, TrailingOnes, Length, Error), pack(0, 0, 0, 0));
        repeat (4) begin
            @(negedge Clk);
            chk("mid_rst_no_stale", 32'(OutValid), 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
